// File: rtl/vga_color_sequencer.sv
// Frame-synchronous colour sequencer: applies jump or per-frame fade colour
// changes to obj_color only at the start of vertical sync.
module vga_color_sequencer #(
    parameter logic [23:0] RESET_COLOR      = 24'h000000,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        vga_clk,
    input  logic        rstn,
    input  logic [23:0] cfg_color,
    input  logic        cfg_we,
    input  logic        cfg_mode,
    input  logic [7:0]  cfg_step,
    input  logic        vsync,
    output logic [23:0] obj_color,
    output logic        busy,
    output logic        upd_done,
    output logic [15:0] frame_cnt
);
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FADE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COLOR_W-1:0]   r_tgt;
    logic [COLOR_W-1:0]   r_color;
    logic [CH_W-1:0]      r_step;
    logic                 r_mode;
    logic                 r_vs_act_q;
    logic                 r_busy;
    logic                 r_upd_done;
    logic [CNT_W-1:0]     r_frame_cnt;

    logic                 w_vs_act;
    logic                 w_vs_start;
    logic                 w_apply;
    logic [COLOR_W-1:0]   w_fade;
    logic                 w_fade_done;
    logic [COLOR_W-1:0]   w_color_nxt;
    logic                 w_upd_nxt;

    // One saturating fade step on a single channel; never overshoots the target.
    function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] tgt,
                                                input logic [CH_W-1:0] cur,
                                                input logic [CH_W-1:0] step);
        logic [CH_W-1:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (diff <= step) ? tgt : CH_W'(cur + step);
        end
        diff = cur - tgt;
        return (diff <= step) ? tgt : CH_W'(cur - step);
    endfunction

    assign w_vs_act    = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign w_vs_start  = w_vs_act & ~r_vs_act_q;
    // A write on the same edge consumes the vsync start.
    assign w_apply     = w_vs_start & ~cfg_we;
    assign w_fade      = {fade_ch(r_tgt[23:16], r_color[23:16], r_step),
                          fade_ch(r_tgt[15:8],  r_color[15:8],  r_step),
                          fade_ch(r_tgt[7:0],   r_color[7:0],   r_step)};
    assign w_fade_done = (w_fade == r_tgt);

    // State register
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_we) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (cfg_we)          w_state_nxt = ST_ARMED;
                else if (w_vs_start) w_state_nxt = (!r_mode || w_fade_done) ? ST_IDLE : ST_FADE;
            end
            ST_FADE: begin
                if (cfg_we)                         w_state_nxt = ST_ARMED;
                else if (w_vs_start && w_fade_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next colour and completion pulse
    always_comb begin
        w_color_nxt = r_color;
        w_upd_nxt   = 1'b0;
        if (w_apply) begin
            case (r_state)
                ST_ARMED: begin
                    w_color_nxt = r_mode ? w_fade : r_tgt;
                    w_upd_nxt   = r_mode ? w_fade_done : 1'b1;
                end
                ST_FADE: begin
                    w_color_nxt = w_fade;
                    w_upd_nxt   = w_fade_done;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            r_tgt       <= RESET_COLOR;
            r_color     <= RESET_COLOR;
            r_step      <= CH_W'(1);
            r_mode      <= 1'b0;
            r_vs_act_q  <= 1'b1;
            r_busy      <= 1'b0;
            r_upd_done  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_act_q  <= w_vs_act;
            r_color     <= w_color_nxt;
            r_upd_done  <= w_upd_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_frame_cnt <= r_frame_cnt + CNT_W'(w_vs_start);
            if (cfg_we) begin
                r_tgt  <= cfg_color;
                r_mode <= cfg_mode;
                r_step <= (cfg_step == '0) ? CH_W'(1) : cfg_step;
            end
        end
    end

    assign obj_color = r_color;
    assign busy      = r_busy;
    assign upd_done  = r_upd_done;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/vga_color_sequencer.md
# vga_color_sequencer

Frame-synchronous colour controller between the LiteX control register output and the VGA controller's `obj_color` input. The CPU writes a target 24-bit colour plus a mode: either an immediate jump or a per-frame fade. The block applies changes only at the start of vertical sync, so a colour never changes mid-frame. It drives `obj_color` directly and reports progress back to the SoC through `busy`, `upd_done` and a frame counter.

## Interface
- `RESET_COLOR`, default 24'h000000: `obj_color` value after reset, as {R[7:0],G[7:0],B[7:0]}.
- `VSYNC_ACTIVE_LOW`, default 1: 1 means `vsync` is asserted low; 0 means asserted high.
- `vga_clk`  in  1  pixel/system clock; the only clock.
- `rstn`  in  1  reset, asynchronous and active-low.
- `cfg_color`  in  24  target colour {R,G,B}; sampled on `cfg_we`.
- `cfg_we`  in  1  one-cycle write strobe.
- `cfg_mode`  in  1  0 = jump, 1 = fade; sampled on `cfg_we`.
- `cfg_step`  in  8  per-frame step per channel in fade mode; 0 is treated as 1; sampled on `cfg_we`.
- `vsync`  in  1  vsync from the VGA controller; same clock domain, so no synchroniser.
- `obj_color`  out  24  colour driven to the VGA controller (registered).
- `busy`  out  1  high whenever state ≠ IDLE.
- `upd_done`  out  1  one-cycle pulse when `obj_color` reaches the target.
- `frame_cnt`  out  16  count of vsync starts; wraps.

## Operation
- **vsync_start**: `vsync` is at its active level this cycle AND `vsync_q` (the previous sample) was inactive.
  - `vsync_q` resets to the active level, so a `vsync` held active across reset release is not a start.
- **Registers**: `tgt[23:0]`, `mode`, `step[7:0]` (stored as max(`cfg_step`,1)), `state`.
- **State IDLE**: `obj_color` == `tgt`. On `cfg_we`: latch `tgt`/`mode`/`step`, go to ARMED.
  - This applies even if `cfg_color` equals the current colour; `upd_done` still pulses at the next vsync_start.
- **State ARMED**: on vsync_start:
  - mode 0: `obj_color` ← `tgt`, pulse `upd_done`, go to IDLE.
  - mode 1: apply one fade step. If the result equals `tgt`, pulse `upd_done` and go to IDLE; otherwise go to FADE.
- **State FADE**: on each vsync_start, apply one fade step. On reaching `tgt`, pulse `upd_done` and go to IDLE.
- **Fade step, per 8-bit channel c**:
  - Compute d = tgt_c − cur_c at 9-bit signed width.
  - If |d| ≤ step: cur_c ← tgt_c.
  - Else if d > 0: cur_c ← cur_c + step; else cur_c ← cur_c − step.
  - Never wraps or overshoots. Channels are independent; a channel already at target holds.
- **Retarget**: `cfg_we` in ARMED or FADE latches the new `tgt`/`mode`/`step` and goes to ARMED. The fade continues from the current `obj_color`; the previous target is abandoned with no `upd_done`.
- **Simultaneous `cfg_we` and vsync_start**: the write wins.
  - The new config is latched and state goes to ARMED.
  - `obj_color` does not change on that edge; the vsync is consumed by the write.
  - `frame_cnt` still increments.
- **frame_cnt**: increments on every vsync_start regardless of state; 16'hFFFF → 0.

## Timing
- **Reset values**: `obj_color` = RESET_COLOR, `tgt` = RESET_COLOR, `busy` = 0, `upd_done` = 0, `frame_cnt` = 0, state = IDLE.
- **Reset mid-fade**: outputs return to the reset values immediately (asynchronous); any pending target is lost.
- **`busy`** rises on the edge after `cfg_we` is sampled.
- **Colour update edge**: `obj_color` changes on the clock edge that first samples `vsync` active, i.e. zero added latency from vsync assertion. `upd_done` and `busy` falling occur on that same edge.
- **`upd_done`** is high for exactly one cycle; it is never asserted while `cfg_we` is high on the same edge.
- **Fade duration**: ceil(max_c |tgt_c − cur_c| / step) frames. Worst case is 255 frames with step 1.

## Test plan
1. **Reset values**: hold `rstn` = 0 for 5 cycles, then release with `vsync` held active → `obj_color` = 000000, `busy` = 0, `frame_cnt` = 0, and no vsync_start on the first edge.
2. **Jump**: `cfg_we` with FF8000, mode 0 → `busy` = 1 on the next edge, `obj_color` holds 000000 until vsync asserts; on that edge `obj_color` = FF8000, `upd_done` pulses for 1 cycle and `busy` = 0.
3. **Fade up**: from 000000, target 1E0A00, step 10 → consecutive frames give 0A0A00, 140A00, 1E0A00; `upd_done` pulses on the third. A repeat with step 0 advances 1 per frame (30 frames).
4. **Fade down with saturation**: from FF0000, target 050000, step 0x40 → BF0000, 7F0000, 3F0000, 050000, with no underflow.
5. **Retarget and collision**: mid-fade, assert `cfg_we` (target 000000) on the same cycle as vsync_start → no colour change and `frame_cnt` +1 on that edge; the next vsync moves toward 000000; no `upd_done` for the old target.
6. **Counter wrap**: drive 65536 vsync pulses → `frame_cnt` wraps to 0. Asserting `rstn` = 0 mid-fade returns `obj_color` to RESET_COLOR asynchronously.
